miriscv_data_arbiter: RTL and testbench

Two-master arbiter for the single data-memory port. Sits between the core's data interface (master 0) and a second bus master such as a DMA/loader (master 1) on one side, and the address decoder/RAM data path on the other. Each accepted request gets a one-cycle-latency response, routed back to the master that issued it. Policy is round-robin, or fixed priority to master 0 when configured.

---
 rtl/miriscv_data_arbiter_if.sv | 23 ++
 rtl/miriscv_data_arbiter.sv | 118 +++++++++++
 tb/tb_miriscv_data_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/miriscv_data_arbiter_if.sv
// Data-memory bus between one master and the arbiter: request attributes out, grant/response back.
// Grant is combinational in the arbiter; response arrives one cycle after the grant.
// Master holds req and its attributes stable until gnt is seen.
interface miriscv_data_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/miriscv_data_arbiter.sv
// Two-master arbiter for the single data-memory port (round-robin or fixed priority to master 0).
// Latency: grant combinational in the request cycle; response (rvalid/rdata) exactly one cycle later.
// Backpressure: a losing master simply keeps req high and is not granted until it wins arbitration.
module miriscv_data_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  miriscv_data_arbiter_if.slave  m0_if,
  miriscv_data_arbiter_if.slave  m1_if,
  output logic                   s_req_o,
  output logic                   s_we_o,
  output logic [3:0]             s_be_o,
  output logic [31:0]            s_addr_o,
  output logic [31:0]            s_wdata_o,
  input  logic [31:0]            s_rdata_i,
  output logic                   owner_o
);

  // last_grant_q resets to 1 so master 0 wins the first round-robin conflict.
  logic last_grant_q, last_grant_d;
  logic resp_valid_q, resp_valid_d;
  logic resp_owner_q, resp_owner_d;
  logic resp_we_q,    resp_we_d;

  logic m0_gnt;
  logic m1_gnt;

  // Arbitration: sole requester wins; on conflict pick master 0 (fixed) or the one not granted last.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n_i) begin
      if (m0_if.req && m1_if.req) begin
        if (FIXED_PRIO || last_grant_q) begin
          m0_gnt = 1'b1;
        end else begin
          m1_gnt = 1'b1;
        end
      end else begin
        m0_gnt = m0_if.req;
        m1_gnt = m1_if.req;
      end
    end
  end

  assign m0_if.gnt = m0_gnt;
  assign m1_if.gnt = m1_gnt;

  // Slave-side request mux; attributes are zeroed when nothing is granted.
  always_comb begin
    s_req_o   = m0_gnt | m1_gnt;
    s_we_o    = 1'b0;
    s_be_o    = 4'b0000;
    s_addr_o  = 32'h0;
    s_wdata_o = 32'h0;
    if (m0_gnt) begin
      s_we_o    = m0_if.we;
      s_be_o    = m0_if.be;
      s_addr_o  = m0_if.addr;
      s_wdata_o = m0_if.wdata;
    end else if (m1_gnt) begin
      s_we_o    = m1_if.we;
      s_be_o    = m1_if.be;
      s_addr_o  = m1_if.addr;
      s_wdata_o = m1_if.wdata;
    end
  end

  // Next-state: remember who was granted and what kind of access the pending response is for.
  always_comb begin
    last_grant_d = last_grant_q;
    resp_valid_d = s_req_o;
    resp_owner_d = resp_owner_q;
    resp_we_d    = resp_we_q;
    if (m0_gnt) begin
      last_grant_d = 1'b0;
    end else if (m1_gnt) begin
      last_grant_d = 1'b1;
    end
    if (s_req_o) begin
      resp_owner_d = m1_gnt;
      resp_we_d    = s_we_o;
    end
  end

  // State registers; async reset discards any response still pending.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_we_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      resp_valid_q <= resp_valid_d;
      resp_owner_q <= resp_owner_d;
      resp_we_q    <= resp_we_d;
    end
  end

  // Response routing: only the owner sees rvalid; rdata is zero for writes and for the non-owner.
  always_comb begin
    m0_if.rvalid = resp_valid_q & ~resp_owner_q;
    m1_if.rvalid = resp_valid_q &  resp_owner_q;
    m0_if.rdata  = 32'h0;
    m1_if.rdata  = 32'h0;
    if (m0_if.rvalid && !resp_we_q) begin
      m0_if.rdata = s_rdata_i;
    end
    if (m1_if.rvalid && !resp_we_q) begin
      m1_if.rdata = s_rdata_i;
    end
  end

  assign owner_o = resp_owner_q;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Directed bench for miriscv_data_arbiter: round-robin and fixed-priority instances share stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Expected values are hand-computed constants per step.
module tb_miriscv_data_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic        m0_we = 1'b0, m1_we = 1'b0;
  logic [3:0]  m0_be = 4'h0, m1_be = 4'h0;
  logic [31:0] m0_addr = 32'h0, m1_addr = 32'h0;
  logic [31:0] m0_wdata = 32'h0, m1_wdata = 32'h0;
  logic [31:0] s_rdata = 32'h0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  miriscv_data_arbiter_if m0_rr();
  miriscv_data_arbiter_if m1_rr();
  miriscv_data_arbiter_if m0_fp();
  miriscv_data_arbiter_if m1_fp();

  assign m0_rr.req = m0_req;  assign m0_rr.we = m0_we;  assign m0_rr.be = m0_be;
  assign m0_rr.addr = m0_addr; assign m0_rr.wdata = m0_wdata;
  assign m1_rr.req = m1_req;  assign m1_rr.we = m1_we;  assign m1_rr.be = m1_be;
  assign m1_rr.addr = m1_addr; assign m1_rr.wdata = m1_wdata;
  assign m0_fp.req = m0_req;  assign m0_fp.we = m0_we;  assign m0_fp.be = m0_be;
  assign m0_fp.addr = m0_addr; assign m0_fp.wdata = m0_wdata;
  assign m1_fp.req = m1_req;  assign m1_fp.we = m1_we;  assign m1_fp.be = m1_be;
  assign m1_fp.addr = m1_addr; assign m1_fp.wdata = m1_wdata;

  logic        rr_s_req, rr_s_we, rr_owner;
  logic [3:0]  rr_s_be;
  logic [31:0] rr_s_addr, rr_s_wdata;
  logic        fp_s_req, fp_s_we, fp_owner;
  logic [3:0]  fp_s_be;
  logic [31:0] fp_s_addr, fp_s_wdata;

  miriscv_data_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n), .m0_if(m0_rr.slave), .m1_if(m1_rr.slave),
    .s_req_o(rr_s_req), .s_we_o(rr_s_we), .s_be_o(rr_s_be), .s_addr_o(rr_s_addr),
    .s_wdata_o(rr_s_wdata), .s_rdata_i(s_rdata), .owner_o(rr_owner)
  );

  miriscv_data_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clk_i(clk), .rst_n_i(rst_n), .m0_if(m0_fp.slave), .m1_if(m1_fp.slave),
    .s_req_o(fp_s_req), .s_we_o(fp_s_we), .s_be_o(fp_s_be), .s_addr_o(fp_s_addr),
    .s_wdata_o(fp_s_wdata), .s_rdata_i(s_rdata), .owner_o(fp_owner)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic req0(input logic r, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = r; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic req1(input logic r, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = r; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wdata;
  endtask

  initial begin
    // Reset: requests asserted but grants must stay low.
    req0(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
    req1(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
    s_rdata = 32'h12345678;
    sample();
    chk("rst_m0_gnt", {31'h0, m0_rr.gnt}, 32'h0);
    chk("rst_m1_gnt", {31'h0, m1_rr.gnt}, 32'h0);
    chk("rst_s_req", {31'h0, rr_s_req}, 32'h0);
    chk("rst_s_addr", rr_s_addr, 32'h0);
    chk("rst_owner", {31'h0, rr_owner}, 32'h0);
    chk("rst_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h0);
    chk("rst_m0_rdata", m0_rr.rdata, 32'h0);
    chk("rst_fp_m0_gnt", {31'h0, m0_fp.gnt}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Conflict after reset: rr grants 0,1,0,1; fp always grants 0.
    req0(1'b1, 1'b0, 4'hF, 32'h100, 32'h0);
    req1(1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    sample();
    chk("c0_rr_m0_gnt", {31'h0, m0_rr.gnt}, 32'h1);
    chk("c0_rr_m1_gnt", {31'h0, m1_rr.gnt}, 32'h0);
    chk("c0_rr_s_addr", rr_s_addr, 32'h100);
    chk("c0_fp_m0_gnt", {31'h0, m0_fp.gnt}, 32'h1);
    chk("c0_fp_m1_gnt", {31'h0, m1_fp.gnt}, 32'h0);
    tick();
    s_rdata = 32'h11111111;
    sample();
    chk("c1_rr_m0_gnt", {31'h0, m0_rr.gnt}, 32'h0);
    chk("c1_rr_m1_gnt", {31'h0, m1_rr.gnt}, 32'h1);
    chk("c1_rr_s_addr", rr_s_addr, 32'h200);
    chk("c1_rr_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h1);
    chk("c1_rr_m0_rdata", m0_rr.rdata, 32'h11111111);
    chk("c1_rr_m1_rvalid", {31'h0, m1_rr.rvalid}, 32'h0);
    chk("c1_rr_owner", {31'h0, rr_owner}, 32'h0);
    chk("c1_fp_m0_gnt", {31'h0, m0_fp.gnt}, 32'h1);
    chk("c1_fp_m1_gnt", {31'h0, m1_fp.gnt}, 32'h0);
    tick();
    s_rdata = 32'h22222222;
    sample();
    chk("c2_rr_m0_gnt", {31'h0, m0_rr.gnt}, 32'h1);
    chk("c2_rr_m1_gnt", {31'h0, m1_rr.gnt}, 32'h0);
    chk("c2_rr_m1_rvalid", {31'h0, m1_rr.rvalid}, 32'h1);
    chk("c2_rr_m1_rdata", m1_rr.rdata, 32'h22222222);
    chk("c2_rr_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h0);
    chk("c2_rr_m0_rdata", m0_rr.rdata, 32'h0);
    chk("c2_rr_owner", {31'h0, rr_owner}, 32'h1);
    chk("c2_fp_m0_gnt", {31'h0, m0_fp.gnt}, 32'h1);
    chk("c2_fp_m1_gnt", {31'h0, m1_fp.gnt}, 32'h0);
    tick();
    sample();
    chk("c3_rr_m1_gnt", {31'h0, m1_rr.gnt}, 32'h1);
    chk("c3_rr_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h1);
    chk("c3_fp_m0_gnt", {31'h0, m0_fp.gnt}, 32'h1);
    chk("c3_fp_m1_gnt", {31'h0, m1_fp.gnt}, 32'h0);
    chk("c3_fp_m1_rvalid", {31'h0, m1_fp.rvalid}, 32'h0);
    tick();
    req0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    req1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("c4_rr_m1_rvalid", {31'h0, m1_rr.rvalid}, 32'h1);
    chk("c4_rr_s_req", {31'h0, rr_s_req}, 32'h0);
    chk("c4_fp_m0_rvalid", {31'h0, m0_fp.rvalid}, 32'h1);
    tick();

    // Single read by m0 at 0x10.
    req0(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    sample();
    chk("rd_m0_gnt", {31'h0, m0_rr.gnt}, 32'h1);
    chk("rd_s_addr", rr_s_addr, 32'h10);
    chk("rd_s_we", {31'h0, rr_s_we}, 32'h0);
    chk("rd_s_req", {31'h0, rr_s_req}, 32'h1);
    tick();
    req0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    s_rdata = 32'hDEADBEEF;
    sample();
    chk("rd_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h1);
    chk("rd_m0_rdata", m0_rr.rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", {31'h0, m1_rr.rvalid}, 32'h0);
    chk("rd_m1_rdata", m1_rr.rdata, 32'h0);
    chk("rd_owner", {31'h0, rr_owner}, 32'h0);
    tick();

    // Back-to-back write then read by m1 at 0x40.
    req1(1'b1, 1'b1, 4'b0011, 32'h40, 32'hA5A5A5A5);
    sample();
    chk("wr_m1_gnt", {31'h0, m1_rr.gnt}, 32'h1);
    chk("wr_s_be", {28'h0, rr_s_be}, 32'h3);
    chk("wr_s_we", {31'h0, rr_s_we}, 32'h1);
    chk("wr_s_wdata", rr_s_wdata, 32'hA5A5A5A5);
    chk("wr_s_addr", rr_s_addr, 32'h40);
    tick();
    req1(1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
    s_rdata = 32'h5A5A5A5A;
    sample();
    chk("b2b_m1_gnt", {31'h0, m1_rr.gnt}, 32'h1);
    chk("b2b_s_we", {31'h0, rr_s_we}, 32'h0);
    chk("b2b_m1_rvalid_c1", {31'h0, m1_rr.rvalid}, 32'h1);
    chk("b2b_m1_rdata_wr", m1_rr.rdata, 32'h0);
    chk("b2b_owner_c1", {31'h0, rr_owner}, 32'h1);
    tick();
    req1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    s_rdata = 32'h0000A5A5;
    sample();
    chk("b2b_m1_rvalid_c2", {31'h0, m1_rr.rvalid}, 32'h1);
    chk("b2b_m1_rdata_rd", m1_rr.rdata, 32'h0000A5A5);
    chk("b2b_m0_rvalid", {31'h0, m0_rr.rvalid}, 32'h0);
    tick();

    // Idle for five cycles.
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("idle_s_req", {31'h0, rr_s_req}, 32'h0);
      chk("idle_s_attr", rr_s_addr | rr_s_wdata | {27'h0, rr_s_be, rr_s_we}, 32'h0);
      chk("idle_rvalid", {30'h0, m0_rr.rvalid, m1_rr.rvalid}, 32'h0);
      chk("idle_rdata", m0_rr.rdata | m1_rr.rdata, 32'h0);
      tick();
    end

    // Reset during a pending m0 response.
    req0(1'b1, 1'b0, 4'hF, 32'h80, 32'h0);
    sample();
    chk("rm_m0_gnt", {31'h0, m0_rr.gnt}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rm_gnt_forced", {31'h0, m0_rr.gnt}, 32'h0);
    tick();
    req0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    sample();
    chk("rm_m0_rvalid_rst", {31'h0, m0_rr.rvalid}, 32'h0);
    chk("rm_m0_rdata_rst", m0_rr.rdata, 32'h0);
    chk("rm_owner_rst", {31'h0, rr_owner}, 32'h0);
    chk("rm_s_req_rst", {31'h0, rr_s_req}, 32'h0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("rm_m0_rvalid_rel", {31'h0, m0_rr.rvalid}, 32'h0);
    tick();
    req0(1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
    req1(1'b1, 1'b0, 4'hF, 32'h400, 32'h0);
    sample();
    chk("rm_conf_m0_gnt", {31'h0, m0_rr.gnt}, 32'h1);
    chk("rm_conf_m1_gnt", {31'h0, m1_rr.gnt}, 32'h0);
    chk("rm_conf_s_addr", rr_s_addr, 32'h300);
    tick();
    req0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    req1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
